// File: rtl/mult_rom_arbiter_if.sv
// Requester, response and RAM-port bundle for the shared times-table ROM.
// slave is the arbiter side, master the requesters and RAM side.
interface mult_rom_arbiter_if #(
  parameter int AW = 3,
  parameter int DW = 6
);
  logic          req0_valid;
  logic          req0_ready;
  logic [AW-1:0] req0_a;
  logic [AW-1:0] req0_b;
  logic          req1_valid;
  logic          req1_ready;
  logic [AW-1:0] req1_a;
  logic [AW-1:0] req1_b;
  logic          resp0_valid;
  logic [DW-1:0] resp0_data;
  logic          resp1_valid;
  logic [DW-1:0] resp1_data;
  logic          mem_en;
  logic [2*AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  mem_dout,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_data,
    output resp1_valid, resp1_data,
    output mem_en, mem_addr
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output mem_dout,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_data,
    input  resp1_valid, resp1_data,
    input  mem_en, mem_addr
  );
endinterface

// File: rtl/mult_rom_arbiter.sv
// Round-robin arbiter sharing one times-table RAM port between two
// requesters; tags each read and routes the product back to its owner.
module mult_rom_arbiter #(
  parameter int AW          = 3,
  parameter int DW          = 6,
  parameter int MEM_LATENCY = 1
) (
  input logic               clk,
  input logic               rst,
  mult_rom_arbiter_if.slave bus
);

  logic ptr;
  logic gnt0;
  logic gnt1;
  logic gnt;
  logic [MEM_LATENCY-1:0] tag_v;
  logic [MEM_LATENCY-1:0] tag_id;
  logic hit0;
  logic hit1;

  // ptr=0 favours requester 0 under contention
  always_comb begin
    gnt0 = !rst && bus.req0_valid
           && (!bus.req1_valid || !ptr);
    gnt1 = !rst && bus.req1_valid
           && (!bus.req0_valid || ptr);
    gnt  = gnt0 || gnt1;
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.mem_en     = gnt;

  always_comb begin
    bus.mem_addr = '0;
    unique case (1'b1)
      gnt0:    bus.mem_addr = {bus.req0_a, bus.req0_b};
      gnt1:    bus.mem_addr = {bus.req1_a, bus.req1_b};
      default: bus.mem_addr = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (gnt) begin
      ptr <= gnt0;
    end
  end

  // tag stage MEM_LATENCY-1 lines up with the RAM data edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= gnt;
      tag_id[0] <= gnt1;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign hit0 = tag_v[MEM_LATENCY-1] && !tag_id[MEM_LATENCY-1];
  assign hit1 = tag_v[MEM_LATENCY-1] &&  tag_id[MEM_LATENCY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.resp0_valid <= 1'b0;
      bus.resp1_valid <= 1'b0;
      bus.resp0_data  <= '0;
      bus.resp1_data  <= '0;
    end else begin
      bus.resp0_valid <= hit0;
      bus.resp1_valid <= hit1;
      if (hit0) begin
        bus.resp0_data <= bus.mem_dout;
      end
      if (hit1) begin
        bus.resp1_data <= bus.mem_dout;
      end
    end
  end

endmodule

// File: tb/tb_mult_rom_arbiter.sv
// Scoreboard bench: drives two arbiters (latency 1 and 3) with the same
// requests, each backed by a behavioural times-table RAM.
module tb_mult_rom_arbiter;

  typedef struct packed {
    logic [5:0] d;
    int         t;
  } exp_t;

  logic clk;
  logic rst;
  logic v0, v1;
  logic [2:0] a0, b0, a1, b1;
  int cnt = 0;
  int checks = 0;
  int errors = 0;
  bit ptr;
  exp_t sb [4][$];
  logic [5:0] last [4];

  logic [5:0] m1, m3a, m3b, m3c;

  mult_rom_arbiter_if #(.AW(3), .DW(6)) bl1 ();
  mult_rom_arbiter_if #(.AW(3), .DW(6)) bl3 ();

  assign bl1.req0_valid = v0;
  assign bl1.req0_a     = a0;
  assign bl1.req0_b     = b0;
  assign bl1.req1_valid = v1;
  assign bl1.req1_a     = a1;
  assign bl1.req1_b     = b1;
  assign bl1.mem_dout   = m1;
  assign bl3.req0_valid = v0;
  assign bl3.req0_a     = a0;
  assign bl3.req0_b     = b0;
  assign bl3.req1_valid = v1;
  assign bl3.req1_a     = a1;
  assign bl3.req1_b     = b1;
  assign bl3.mem_dout   = m3c;

  mult_rom_arbiter #(.AW(3), .DW(6), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bl1)
  );
  mult_rom_arbiter #(.AW(3), .DW(6), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bl3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  // RAM models: douta = a*b, MEM_LATENCY clocks after the address edge
  always @(posedge clk) begin
    if (bl1.mem_en)
      m1 <= 6'(bl1.mem_addr[5:3]) * 6'(bl1.mem_addr[2:0]);
    if (bl3.mem_en)
      m3a <= 6'(bl3.mem_addr[5:3]) * 6'(bl3.mem_addr[2:0]);
    m3b <= m3a;
    m3c <= m3b;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               nm, act, exp, cnt);
    end
  endtask

  task automatic side(input int i, input logic v, input logic [5:0] d);
    exp_t e;
    if (v) begin
      if (sb[i].size() == 0) begin
        chk($sformatf("unexpected_resp_q%0d", i), 1, 0);
      end else begin
        e = sb[i].pop_front();
        chk($sformatf("resp_data_q%0d", i), int'(d), int'(e.d));
        chk($sformatf("resp_time_q%0d", i), cnt, e.t);
        last[i] = e.d;
      end
    end else begin
      chk($sformatf("resp_hold_q%0d", i), int'(d), int'(last[i]));
    end
  endtask

  task automatic mon(input int k,
                     input logic va, input logic [5:0] da,
                     input logic vb, input logic [5:0] db);
    chk($sformatf("both_valid_k%0d", k), int'(va && vb), 0);
    side(2*k, va, da);
    side(2*k+1, vb, db);
  endtask

  always @(negedge clk) begin
    mon(0, bl1.resp0_valid, bl1.resp0_data,
        bl1.resp1_valid, bl1.resp1_data);
    mon(1, bl3.resp0_valid, bl3.resp0_data,
        bl3.resp1_valid, bl3.resp1_data);
  end

  task automatic zero_chk();
    chk("rst_ready0_l1", int'(bl1.req0_ready), 0);
    chk("rst_ready1_l1", int'(bl1.req1_ready), 0);
    chk("rst_mem_en_l1", int'(bl1.mem_en), 0);
    chk("rst_rv0_l1", int'(bl1.resp0_valid), 0);
    chk("rst_rv1_l1", int'(bl1.resp1_valid), 0);
    chk("rst_rd0_l1", int'(bl1.resp0_data), 0);
    chk("rst_rd1_l1", int'(bl1.resp1_data), 0);
    chk("rst_ready0_l3", int'(bl3.req0_ready), 0);
    chk("rst_ready1_l3", int'(bl3.req1_ready), 0);
    chk("rst_mem_en_l3", int'(bl3.mem_en), 0);
    chk("rst_rv0_l3", int'(bl3.resp0_valid), 0);
    chk("rst_rv1_l3", int'(bl3.resp1_valid), 0);
    chk("rst_rd0_l3", int'(bl3.resp0_data), 0);
    chk("rst_rd1_l3", int'(bl3.resp1_data), 0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 zero_chk();
    for (int i = 0; i < 4; i++) begin
      sb[i].delete();
      last[i] = '0;
    end
    ptr = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
    rst = 1'b0;
  endtask

  task automatic cyc(input bit iv0, input int ia0, input int ib0,
                     input bit iv1, input int ia1, input int ib1);
    int g;
    int p;
    logic [5:0] ea;
    exp_t e;
    @(posedge clk);
    #1;
    v0 = iv0; a0 = 3'(ia0); b0 = 3'(ib0);
    v1 = iv1; a1 = 3'(ia1); b1 = 3'(ib1);
    if (iv0 && iv1) g = ptr ? 2 : 1;
    else if (iv0)   g = 1;
    else if (iv1)   g = 2;
    else            g = 0;
    @(negedge clk);
    ea = (g == 1) ? {a0, b0} : (g == 2) ? {a1, b1} : 6'd0;
    p  = (g == 1) ? ia0 * ib0 : ia1 * ib1;
    chk("ready0_l1", int'(bl1.req0_ready), int'(g == 1));
    chk("ready1_l1", int'(bl1.req1_ready), int'(g == 2));
    chk("mem_en_l1", int'(bl1.mem_en), int'(g != 0));
    chk("mem_addr_l1", int'(bl1.mem_addr), int'(ea));
    chk("ready0_l3", int'(bl3.req0_ready), int'(g == 1));
    chk("ready1_l3", int'(bl3.req1_ready), int'(g == 2));
    chk("mem_en_l3", int'(bl3.mem_en), int'(g != 0));
    chk("mem_addr_l3", int'(bl3.mem_addr), int'(ea));
    if (g != 0) begin
      e.d = 6'(p);
      e.t = cnt + 2;
      sb[g-1].push_back(e);
      e.t = cnt + 4;
      sb[g+1].push_back(e);
      ptr = (g == 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    v0 = 1'b0; a0 = '0; b0 = '0;
    v1 = 1'b0; a1 = '0; b1 = '0;
    ptr = 1'b0;
    for (int i = 0; i < 4; i++) last[i] = '0;
    repeat (2) @(posedge clk);
    #1 zero_chk();
    #1 rst = 1'b0;

    cyc(1, 3, 5, 0, 0, 0);
    idle(5);

    do_reset(2);
    repeat (4) cyc(1, 7, 7, 1, 2, 6);
    idle(5);

    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, i, 7);
    cyc(1, 1, 1, 1, 2, 2);
    cyc(1, 1, 1, 1, 2, 2);
    idle(5);

    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 7, 0);
    cyc(1, 0, 7, 0, 0, 0);
    cyc(0, 0, 0, 1, 7, 7);
    idle(5);

    cyc(1, 2, 3, 0, 0, 0);
    cyc(1, 5, 6, 1, 3, 3);
    cyc(1, 5, 6, 0, 0, 0);
    idle(5);

    cyc(1, 4, 4, 0, 0, 0);
    do_reset(2);
    cyc(1, 6, 6, 1, 5, 5);
    cyc(1, 6, 6, 1, 5, 5);
    idle(6);

    for (int i = 0; i < 4; i++)
      chk($sformatf("drained_q%0d", i), sb[i].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
